// File: rtl/parking_gate_arbiter.sv
// Arbitrates the single car-park barrier between the entry and exit lanes,
// holds the gate for one car pass (or a timeout) and tracks lot occupancy.
`timescale 1ns / 1ps

module parking_gate_arbiter #(
    parameter int CAPACITY     = 8,
    parameter int CNT_W        = 4,
    parameter int OPEN_CYCLES  = 16,
    parameter int CLOSE_CYCLES = 4,
    parameter int TIMER_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_passed,
    output logic             gate_open,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN_ENTRY,
        OPEN_EXIT,
        CLOSING
    } state_t;

    typedef enum logic {
        LANE_ENTRY,
        LANE_EXIT
    } lane_t;

    localparam logic [CNT_W-1:0]   CAP        = CNT_W'(CAPACITY);
    localparam logic [TIMER_W-1:0] OPEN_LAST  = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CLOSE_LAST = TIMER_W'(CLOSE_CYCLES - 1);

    state_t             state_q, state_d;
    lane_t              last_q, last_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               gate_q, gate_d;
    logic               grant_entry_q, grant_entry_d;
    logic               grant_exit_q, grant_exit_d;
    logic               timeout_q, timeout_d;

    logic full_w, empty_w;
    logic entry_ok, exit_ok;

    assign full_w   = (occ_q >= CAP);
    assign empty_w  = (occ_q == '0);
    assign entry_ok = entry_req & ~full_w;
    assign exit_ok  = exit_req & ~empty_w;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_d   = state_q;
        last_d    = last_q;
        timer_d   = timer_q;
        occ_d     = occ_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                // On a tie the lane that was not served last wins.
                if (entry_ok && (!exit_ok || last_q == LANE_EXIT)) begin
                    state_d = OPEN_ENTRY;
                    last_d  = LANE_ENTRY;
                end else if (exit_ok) begin
                    state_d = OPEN_EXIT;
                    last_d  = LANE_EXIT;
                end
            end

            OPEN_ENTRY, OPEN_EXIT: begin
                if (car_passed) begin
                    if (state_q == OPEN_ENTRY) begin
                        if (occ_q < CAP) occ_d = occ_q + 1'b1;
                    end else begin
                        if (occ_q != '0) occ_d = occ_q - 1'b1;
                    end
                    state_d = CLOSING;
                    timer_d = '0;
                end else if (timer_q == OPEN_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = CLOSING;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            CLOSING: begin
                if (timer_q == CLOSE_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        grant_entry_d = (state_d == OPEN_ENTRY);
        grant_exit_d  = (state_d == OPEN_EXIT);
        gate_d        = grant_entry_d | grant_exit_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= LANE_EXIT;
            timer_q       <= '0;
            occ_q         <= '0;
            gate_q        <= 1'b0;
            grant_entry_q <= 1'b0;
            grant_exit_q  <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            timer_q       <= timer_d;
            occ_q         <= occ_d;
            gate_q        <= gate_d;
            grant_entry_q <= grant_entry_d;
            grant_exit_q  <= grant_exit_d;
            timeout_q     <= timeout_d;
        end
    end

    assign gate_open   = gate_q;
    assign grant_entry = grant_entry_q;
    assign grant_exit  = grant_exit_q;
    assign occupancy   = occ_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign timeout_err = timeout_q;

endmodule
